// File: rtl/fir_out_buffer.sv
// Output buffer for the FIR core: decimator followed by a first-word-fall-through
// FIFO with level interrupt and sticky overflow / drop counting.
module fir_out_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               decim,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_sample,
  output logic                     m_valid,
  output logic [DATA_W-1:0]        m_data,
  input  logic                     m_ready,
  input  logic [ADDR_W:0]          thresh,
  output logic [ADDR_W:0]          level,
  output logic                     irq_level,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned LVL_W = ADDR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [LVL_W-1:0]  lvl;
  logic [LVL_W-1:0]  lvl_nxt;
  logic [7:0]        dcnt;
  logic [7:0]        dcnt_nxt;
  logic              keep;
  logic              pop;
  logic              full;
  logic              wr;
  logic              drop;
  logic              irq_nxt;

  // Decimator: a stale count above the new factor is treated as already wrapped.
  always_comb begin
    keep     = 1'b0;
    dcnt_nxt = dcnt;
    if (in_valid) begin
      if (decim <= 8'd1) begin
        keep     = 1'b1;
        dcnt_nxt = 8'd0;
      end else if (dcnt >= decim) begin
        keep     = 1'b0;
        dcnt_nxt = 8'd1;
      end else begin
        keep     = (dcnt == 8'd0);
        dcnt_nxt = (dcnt == (decim - 8'd1)) ? 8'd0 : dcnt + 8'd1;
      end
    end
  end

  // FIFO handshake: a pop frees the slot that a write at full may reuse.
  always_comb begin
    pop   = (lvl != '0) && m_ready;
    full  = (lvl == FULL_LVL);
    wr    = keep && (!full || pop);
    drop  = keep && full && !pop;
    case ({wr, pop})
      2'b10:   lvl_nxt = lvl + LVL_W'(1);
      2'b01:   lvl_nxt = lvl - LVL_W'(1);
      default: lvl_nxt = lvl;
    endcase
    irq_nxt = (thresh != '0) && (lvl_nxt >= thresh);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      lvl       <= '0;
      dcnt      <= 8'd0;
      irq_level <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= 16'd0;
    end else begin
      dcnt      <= dcnt_nxt;
      lvl       <= lvl_nxt;
      irq_level <= irq_nxt;
      if (wr)  wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (ovf_clr)                  drop_cnt <= 16'd1;
        else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
        drop_cnt <= 16'd0;
      end
    end
  end

  // Storage is left unreset; reads are masked while empty.
  always_ff @(posedge clk) begin
    if (rst_n && !clear && wr) mem[wr_ptr] <= in_sample;
  end

  assign level   = lvl;
  assign m_valid = (lvl != '0);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fir_out_buffer.sv
// Directed bench for fir_out_buffer: decimation, FWFT ordering, full/overflow,
// level interrupt, clear and reset behaviour.
module tb_fir_out_buffer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic                     clk;
  logic                     rst_n;
  logic [7:0]               decim;
  logic                     clear;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_sample;
  logic                     m_valid;
  logic [DATA_W-1:0]        m_data;
  logic                     m_ready;
  logic [ADDR_W:0]          thresh;
  logic [ADDR_W:0]          level;
  logic                     irq_level;
  logic                     overflow;
  logic                     ovf_clr;
  logic [15:0]              drop_cnt;

  int passed;
  int total;

  fir_out_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .decim(decim), .clear(clear),
    .in_valid(in_valid), .in_sample(in_sample),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .thresh(thresh), .level(level), .irq_level(irq_level),
    .overflow(overflow), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int val);
    in_valid  = 1'b1;
    in_sample = DATA_W'(val);
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    passed = 0; total = 0;
    rst_n = 1'b0; decim = 8'd0; clear = 1'b0; in_valid = 1'b0; in_sample = '0;
    m_ready = 1'b0; thresh = '0; ovf_clr = 1'b0;
    tick(); tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_irq", irq_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drops", drop_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Pass-through, one cycle latency, popped as the next sample arrives.
    m_ready = 1'b1;
    pulse(10);
    chk("pt_valid1", m_valid, 1);
    chk("pt_data1", m_data, 10);
    pulse(20);
    chk("pt_data2", m_data, 20);
    chk("pt_level2", level, 1);
    pulse(30);
    chk("pt_data3", m_data, 30);
    tick();
    chk("pt_level_end", level, 0);
    chk("pt_valid_end", m_valid, 0);

    // Decimate by 3 keeps 1, 4, 7.
    m_ready = 1'b0; decim = 8'd3;
    for (int i = 1; i <= 9; i++) pulse(i);
    chk("dec_level", level, 3);
    m_ready = 1'b1;
    chk("dec_pop1", m_data, 1);
    tick();
    chk("dec_pop2", m_data, 4);
    tick();
    chk("dec_pop3", m_data, 7);
    tick();
    chk("dec_empty", level, 0);
    m_ready = 1'b0; decim = 8'd0;

    // Overfill by two.
    for (int i = 0; i < 18; i++) pulse(100 + i);
    chk("ovf_level", level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drops", drop_cnt, 2);
    chk("ovf_stable", m_data, 100);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_pop%0d", i), m_data, 64'(100 + i));
      tick();
    end
    chk("ovf_drained", m_valid, 0);
    m_ready = 1'b0;
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovfclr_flag", overflow, 0);
    chk("ovfclr_drops", drop_cnt, 0);

    // Full: drop racing ovf_clr, then write with simultaneous pop.
    for (int i = 0; i < 16; i++) pulse(200 + i);
    chk("full_level", level, 16);
    ovf_clr = 1'b1; pulse(999); ovf_clr = 1'b0;
    chk("race_flag", overflow, 1);
    chk("race_drops", drop_cnt, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("race_clr", overflow, 0);
    m_ready = 1'b1; pulse(300); m_ready = 1'b0;
    chk("fullpop_level", level, 16);
    chk("fullpop_ovf", overflow, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("fullpop_pop%0d", i), m_data, 64'(201 + i));
      tick();
    end
    chk("fullpop_last", m_data, 300);
    tick();
    chk("fullpop_empty", level, 0);
    m_ready = 1'b0;

    // Level interrupt.
    thresh = 5'd4;
    pulse(1); pulse(2); pulse(3);
    chk("irq_below", irq_level, 0);
    pulse(4);
    chk("irq_at", irq_level, 1);
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    chk("irq_pop_level", level, 3);
    chk("irq_pop", irq_level, 0);
    thresh = 5'd0;
    pulse(5);
    chk("irq_zero_level", level, 4);
    chk("irq_zero", irq_level, 0);

    // Clear beats simultaneous write, pop and ovf_clr.
    thresh = 5'd2;
    pulse(6);
    chk("clr_pre_irq", irq_level, 1);
    clear = 1'b1; m_ready = 1'b1; ovf_clr = 1'b1; pulse(77);
    clear = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
    chk("clr_level", level, 0);
    chk("clr_valid", m_valid, 0);
    chk("clr_data", m_data, 0);
    chk("clr_irq", irq_level, 0);

    // Reset mid-stream with level 5.
    for (int i = 0; i < 5; i++) pulse(40 + i);
    chk("rs_pre_level", level, 5);
    rst_n = 1'b0; pulse(88); rst_n = 1'b1;
    chk("rs_level", level, 0);
    chk("rs_data", m_data, 0);
    chk("rs_irq", irq_level, 0);
    tick();
    chk("rs_post_valid", m_valid, 0);

    // Decimation factor shrinks below the running count.
    thresh = 5'd0; decim = 8'd4;
    pulse(501); pulse(502);
    decim = 8'd2;
    pulse(503); pulse(504); pulse(505);
    chk("dchg_level", level, 2);
    m_ready = 1'b1;
    chk("dchg_first", m_data, 501);
    tick();
    chk("dchg_second", m_data, 505);
    tick();
    m_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fir_out_buffer.md
FIR_OUT_BUFFER -- requirements
Module: fir_out_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning sample width, which matches the FIR core output width.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have parameter ADDR_W, default 4, meaning log2(DEPTH).
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port decim, input, 8 bits: decimation factor; 0 or 1 means keep every sample.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous flush of FIFO, decimator and flags.
REQ-008 The block SHALL have port in_valid, input, 1 bit: one-cycle pulse from the FIR core out_valid.
REQ-009 The block SHALL have port in_sample, input, DATA_W bits, signed: sample qualified by in_valid.
REQ-010 The block SHALL have port m_valid, output, 1 bit: output stream valid.
REQ-011 The block SHALL have port m_data, output, DATA_W bits: output stream data.
REQ-012 The block SHALL have port m_ready, input, 1 bit: consumer ready.
REQ-013 The block SHALL have port thresh, input, ADDR_W+1 bits: level threshold for irq_level.
REQ-014 The block SHALL have port level, output, ADDR_W+1 bits: current occupancy, range 0..DEPTH.
REQ-015 The block SHALL have port irq_level, output, 1 bit: registered, asserted when level >= thresh and thresh != 0.
REQ-016 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a kept sample is dropped.
REQ-017 The block SHALL have port ovf_clr, input, 1 bit: clears overflow and drop_cnt.
REQ-018 The block SHALL have port drop_cnt, output, 16 bits: saturating count of dropped kept samples.

Function
REQ-019 The input side SHALL have no backpressure: every in_valid pulse SHALL be processed in its own cycle.
REQ-020 The decimator counter dcnt SHALL advance on each in_valid.
REQ-021 A sample SHALL be kept only when dcnt == 0.
REQ-022 dcnt SHALL wrap to 0 after reaching decim-1.
REQ-023 When decim <= 1, every sample SHALL be kept and dcnt SHALL stay at 0.
REQ-024 If decim changes so that dcnt >= decim, the next in_valid SHALL treat dcnt as wrapped: the sample SHALL be dropped by the decimator and dcnt SHALL become 1, or 0 if decim <= 1.
REQ-025 A kept sample SHALL be written at the rising edge ending its in_valid cycle when not full, or when full with a simultaneous read.
REQ-026 The FIFO SHALL be first-word-fall-through: m_valid = (level != 0), and m_data = the entry at the read pointer, driven combinationally from registers.
REQ-027 A pop SHALL occur when m_valid && m_ready.
REQ-028 m_data and m_valid SHALL be stable while m_valid && !m_ready.
REQ-029 Latency: a sample kept in cycle N SHALL make m_valid high in cycle N+1 when the FIFO was empty; there is no same-cycle bypass.
REQ-030 Write at full with a pop in the same cycle: the write SHALL be accepted, level SHALL be unchanged, and there SHALL be no overflow.
REQ-031 Write at full without a pop: the sample SHALL be discarded, FIFO contents SHALL be unchanged, overflow SHALL be set to 1, and drop_cnt SHALL increment, saturating at 0xFFFF.
REQ-032 Simultaneous write and pop when not full and not empty SHALL leave level unchanged.
REQ-033 Read and write pointers SHALL be ADDR_W bits and SHALL wrap modulo DEPTH.
REQ-034 level SHALL be a separate counter.
REQ-035 Simultaneous drop and ovf_clr: the set SHALL win, giving overflow = 1 and drop_cnt = 1.
REQ-036 clear SHALL have priority over in_valid, pop and ovf_clr in the same cycle.
REQ-037 On clear, the next state SHALL be: pointers 0, level 0, dcnt 0, overflow 0, drop_cnt 0, irq_level 0.
REQ-038 irq_level SHALL be registered from the post-update level, i.e. it lags level by 0 cycles relative to the registered level value.

Reset
REQ-039 While rst_n = 0 at a clock edge, the block SHALL reset with the same state as clear: m_valid 0, level 0, irq_level 0, overflow 0, drop_cnt 0, dcnt 0.
REQ-040 While rst_n = 0 at a clock edge, m_data SHALL be 0.
REQ-041 Reset mid-stream SHALL discard all buffered samples, and no m_valid SHALL occur in the cycle after reset release.
REQ-042 FIFO storage contents SHALL NOT require reset; m_data SHALL be masked to 0 while level == 0.

Verification
REQ-043 Scenario: decim = 0, pulses 10, 20, 30 with m_ready = 1 -> m_data = 10, 20, 30 in order, each appearing 1 cycle after its pulse, and level returns to 0.
REQ-044 Scenario: decim = 3, pulses 1..9 with m_ready = 0 -> level = 3, and pops yield 1, 4, 7.
REQ-045 Scenario: DEPTH = 16, m_ready = 0, 18 pulses -> level = 16, overflow = 1, drop_cnt = 2, and pops yield the first 16 samples.
REQ-046 Scenario: FIFO full, pulse coinciding with m_ready = 1 -> level stays 16, overflow stays 0, and the new sample emerges last.
REQ-047 Scenario: thresh = 4, 4 pulses -> irq_level = 1 once level = 4; one pop -> irq_level = 0; thresh = 0 -> irq_level stays 0.
REQ-048 Scenario: clear asserted with in_valid and m_ready in the same cycle, and separately rst_n pulsed with level = 5 -> all outputs 0 next cycle, and no sample is written.
